match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 The parameters SHALL be:
- TURN_TICKS, default 10: clk_slow cycles allowed per turn, range 1..15.
- WIN_ROUNDS, default 2: round wins needed to take the match, range 1..3.
REQ-002 The ports SHALL be as follows; all outputs are registered.
- clk_slow  in  1  single clock, all state updates on its rising edge.
- btn_rst_n  in  1  reset, asynchronous, active-low.
- btn_start  in  1  start or restart a match (level; rising edge used).
- btn_sub, btn_sub_h, btn_add, btn_add_h  in  1 each  raw move buttons (level, already synchronized).
- win  in  1  round-won flag from the game datapath.
- plr_turn  in  1  current player from the game datapath.
- game_rst  out  1  active-high reset pulse to the game datapath.
- mv_sub, mv_sub_h, mv_add, mv_add_h  out  1 each  one-cycle move pulses to the game datapath.
- turn_left  out  4  cycles remaining in the current turn.
- score0, score1  out  2 each  rounds won by player 0 and player 1.
- match_over  out  1  match finished.
- match_winner  out  1  winning player; valid while match_over=1.

Function
REQ-003 The FSM SHALL have four states, IDLE, LOAD, PLAY and DONE, with the following transitions.
- IDLE goes to LOAD on a btn_start rising edge.
- LOAD goes to PLAY after exactly 1 cycle.
- PLAY goes to LOAD or DONE when a round ends (REQ-008).
- DONE goes to LOAD on a btn_start rising edge.
REQ-004 game_rst SHALL be 1 for exactly the single cycle the FSM is in LOAD, and 0 in every other cycle.
REQ-005 Rising-edge detection SHALL work as follows.
- Each move button and btn_start has its own previous-value register.
- An edge is current=1 while previous=0.
- A button held high SHALL produce only one edge.
REQ-006 Move arbitration in PLAY SHALL work as follows.
- At most one mv_* pulse is high in any cycle.
- Priority is sub > sub_h > add > add_h.
- Lower-priority edges arriving in the same cycle are discarded, not queued.
- Each pulse lasts exactly 1 cycle and appears 1 cycle after the edge is sampled.
REQ-007 mv_* SHALL stay 0 in IDLE, LOAD and DONE; edges seen in those states are dropped.
REQ-008 Round end in PLAY SHALL work as follows.
- win=1 ends the round; the winner is plr_turn.
- Otherwise, turn_left=0 (timeout) ends the round; the winner is ~plr_turn.
- win and timeout in the same cycle: win takes precedence.
REQ-009 When a round ends:
- The winner's score increments.
- If the new score equals WIN_ROUNDS, the FSM goes to DONE, match_over=1 and match_winner=winner.
- Otherwise the FSM goes to LOAD.
REQ-010 The turn timer SHALL behave as follows.
- turn_left loads TURN_TICKS in LOAD.
- It reloads TURN_TICKS in any PLAY cycle where plr_turn differs from its value registered the previous cycle.
- Otherwise it decrements by 1 per PLAY cycle and saturates at 0.
- It holds its value in IDLE and DONE.
REQ-011 A btn_start edge in DONE SHALL clear score0, score1, match_over and match_winner in the same cycle the FSM enters LOAD.
REQ-012 A btn_start edge in LOAD or PLAY SHALL be ignored.
REQ-013 Scores SHALL never exceed WIN_ROUNDS; no wrap-around is permitted.

Reset
REQ-014 btn_rst_n=0 SHALL immediately, without waiting for a clock edge, set:
- FSM to IDLE;
- game_rst=0, mv_*=0, turn_left=0;
- score0=score1=0, match_over=0, match_winner=0.
REQ-015 During reset all edge-detect previous-value registers SHALL be set to 1, so a button held through reset release produces no edge.
REQ-016 Reset asserted mid-PLAY SHALL abandon the round with no score change recorded.
REQ-017 After reset release, a fresh btn_start edge SHALL be required to begin.

Configuration
REQ-018 With macro MATCH_CTRL_TURN_TIMER_EN defined, the timer and timeout SHALL operate per REQ-008 and REQ-010.
REQ-019 With MATCH_CTRL_TURN_TIMER_EN undefined:
- turn_left SHALL be constant 0;
- timeout SHALL never end a round; only win ends a round.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (TURN_TICKS=10, WIN_ROUNDS=2, timer enabled unless stated).
- Start: reset, btn_start 0->1 -> game_rst=1 for 1 cycle, then PLAY with turn_left=10.
- Arbitration: btn_sub and btn_add rise in the same cycle -> only mv_sub=1 for 1 cycle; holding both 5 cycles -> no further pulses.
- Timeout: plr_turn=0 held 10 PLAY cycles with win=0 -> score1=1, game_rst pulses; win=1 in the same cycle as turn_left=0 -> player 0 credited instead.
- Match: player 0 wins two rounds via win=1 -> score0=2, match_over=1, match_winner=0; btn_start -> scores 0, LOAD.
- Reset: btn_rst_n low mid-PLAY with score1=1 -> score1=0, IDLE, no mv_* pulse while btn_sub is held across release.
- Timer disabled: MATCH_CTRL_TURN_TIMER_EN undefined, 50 cycles with no move -> turn_left=0, no score change.

Source files
------------

// File: rtl/match_ctrl_if.sv
// Signal bundle between match_ctrl and the game datapath / button front end.
// The slave modport is the controller's view; master is the driving side.
interface match_ctrl_if;
  logic       btn_start;
  logic       btn_sub;
  logic       btn_sub_h;
  logic       btn_add;
  logic       btn_add_h;
  logic       win;
  logic       plr_turn;

  logic       game_rst;
  logic       mv_sub;
  logic       mv_sub_h;
  logic       mv_add;
  logic       mv_add_h;
  logic [3:0] turn_left;
  logic [1:0] score0;
  logic [1:0] score1;
  logic       match_over;
  logic       match_winner;

  modport slave (
    input  btn_start, btn_sub, btn_sub_h, btn_add, btn_add_h, win, plr_turn,
    output game_rst, mv_sub, mv_sub_h, mv_add, mv_add_h,
    output turn_left, score0, score1, match_over, match_winner
  );

  modport master (
    output btn_start, btn_sub, btn_sub_h, btn_add, btn_add_h, win, plr_turn,
    input  game_rst, mv_sub, mv_sub_h, mv_add, mv_add_h,
    input  turn_left, score0, score1, match_over, match_winner
  );
endinterface

// File: rtl/match_ctrl.sv
// Match controller: start/round/match sequencing, move-button arbitration and scoring.
// Define MATCH_CTRL_TURN_TIMER_EN to enable the per-turn timeout timer.
module match_ctrl #(
  parameter int TURN_TICKS = 10,
  parameter int WIN_ROUNDS = 2
) (
  input  logic         clk_slow,
  input  logic         btn_rst_n,
  match_ctrl_if.slave  bus
);

  localparam logic [3:0] TICKS = 4'(TURN_TICKS);
  localparam logic [1:0] WINS  = 2'(WIN_ROUNDS);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_prev_start;
  logic       r_prev_sub;
  logic       r_prev_sub_h;
  logic       r_prev_add;
  logic       r_prev_add_h;
  logic       w_start_edge;
  logic [3:0] w_move_edge;

  logic       w_timeout;
  logic       w_round_end;
  logic       w_winner;
  logic [1:0] w_winner_score;
  logic       w_match_won;

  logic [3:0] w_mv_nx;
  logic       w_game_rst_nx;
  logic [3:0] r_mv;
  logic       r_game_rst;

  logic [1:0] r_score0;
  logic [1:0] r_score1;
  logic       r_match_over;
  logic       r_match_winner;

  // Previous-value registers preset to 1 so a button held through reset yields no edge.
  always_ff @(posedge clk_slow or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_prev_start <= 1'b1;
      r_prev_sub   <= 1'b1;
      r_prev_sub_h <= 1'b1;
      r_prev_add   <= 1'b1;
      r_prev_add_h <= 1'b1;
    end else begin
      r_prev_start <= bus.btn_start;
      r_prev_sub   <= bus.btn_sub;
      r_prev_sub_h <= bus.btn_sub_h;
      r_prev_add   <= bus.btn_add;
      r_prev_add_h <= bus.btn_add_h;
    end
  end

  assign w_start_edge = bus.btn_start & ~r_prev_start;
  assign w_move_edge  = {bus.btn_sub   & ~r_prev_sub,
                         bus.btn_sub_h & ~r_prev_sub_h,
                         bus.btn_add   & ~r_prev_add,
                         bus.btn_add_h & ~r_prev_add_h};

`ifdef MATCH_CTRL_TURN_TIMER_EN
  logic       r_prev_turn;
  logic [3:0] r_turn_left;

  // A change of player restarts the turn budget; otherwise count down and stick at 0.
  always_ff @(posedge clk_slow or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_prev_turn <= 1'b0;
      r_turn_left <= 4'd0;
    end else begin
      r_prev_turn <= bus.plr_turn;
      case (r_state)
        LOAD:    r_turn_left <= TICKS;
        PLAY: begin
          if (bus.plr_turn != r_prev_turn)
            r_turn_left <= TICKS;
          else if (r_turn_left != 4'd0)
            r_turn_left <= r_turn_left - 4'd1;
        end
        default: r_turn_left <= r_turn_left;
      endcase
    end
  end

  assign w_timeout     = (r_turn_left == 4'd0);
  assign bus.turn_left = r_turn_left;
`else
  assign w_timeout     = 1'b0;
  assign bus.turn_left = 4'd0;
`endif

  // Win outranks a simultaneous timeout; a timeout credits the idle player's opponent.
  assign w_round_end    = (r_state == PLAY) && (bus.win || w_timeout);
  assign w_winner       = bus.win ? bus.plr_turn : ~bus.plr_turn;
  assign w_winner_score = w_winner ? (r_score1 + 2'd1) : (r_score0 + 2'd1);
  assign w_match_won    = (w_winner_score == WINS);

  always_ff @(posedge clk_slow or negedge btn_rst_n) begin
    if (!btn_rst_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_start_edge) w_next_state = LOAD;
      LOAD: w_next_state = PLAY;
      PLAY: if (w_round_end) w_next_state = w_match_won ? DONE : LOAD;
      DONE: if (w_start_edge) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  // Moves only pass while play continues into the next cycle, so no pulse lands in LOAD/DONE.
  always_comb begin
    w_mv_nx       = 4'b0000;
    w_game_rst_nx = (w_next_state == LOAD);
    if ((r_state == PLAY) && (w_next_state == PLAY)) begin
      if (w_move_edge[3])      w_mv_nx = 4'b1000;
      else if (w_move_edge[2]) w_mv_nx = 4'b0100;
      else if (w_move_edge[1]) w_mv_nx = 4'b0010;
      else if (w_move_edge[0]) w_mv_nx = 4'b0001;
    end
  end

  always_ff @(posedge clk_slow or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_mv       <= 4'b0000;
      r_game_rst <= 1'b0;
    end else begin
      r_mv       <= w_mv_nx;
      r_game_rst <= w_game_rst_nx;
    end
  end

  always_ff @(posedge clk_slow or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_score0       <= 2'd0;
      r_score1       <= 2'd0;
      r_match_over   <= 1'b0;
      r_match_winner <= 1'b0;
    end else if (w_round_end) begin
      if (w_winner) r_score1 <= w_winner_score;
      else          r_score0 <= w_winner_score;
      if (w_match_won) begin
        r_match_over   <= 1'b1;
        r_match_winner <= w_winner;
      end
    end else if ((r_state == DONE) && w_start_edge) begin
      r_score0       <= 2'd0;
      r_score1       <= 2'd0;
      r_match_over   <= 1'b0;
      r_match_winner <= 1'b0;
    end
  end

  assign bus.game_rst     = r_game_rst;
  assign bus.mv_sub       = r_mv[3];
  assign bus.mv_sub_h     = r_mv[2];
  assign bus.mv_add       = r_mv[1];
  assign bus.mv_add_h     = r_mv[0];
  assign bus.score0       = r_score0;
  assign bus.score1       = r_score1;
  assign bus.match_over   = r_match_over;
  assign bus.match_winner = r_match_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// Testbench for match_ctrl: directed stimulus with a queue-based scoreboard.
// Expectations are pushed at stimulus time and popped by a monitor on output activity or probes.
module tb_match_ctrl;

`ifdef MATCH_CTRL_TURN_TIMER_EN
  localparam logic [3:0] TL = 4'd10;
`else
  localparam logic [3:0] TL = 4'd0;
`endif

  typedef struct {
    string      name;
    logic [3:0] mv;
    logic       gr;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       over;
    logic       winner;
    logic       chkTurn;
    logic [3:0] turn;
  } item_t;

  logic  clk_slow  = 1'b0;
  logic  btn_rst_n = 1'b0;
  logic  probeReq  = 1'b0;
  logic  finishReq = 1'b0;
  logic  doneFlag  = 1'b0;
  int    checks    = 0;
  int    errors    = 0;
  item_t sbQ[$];

  match_ctrl_if bus ();

  match_ctrl #(.TURN_TICKS(10), .WIN_ROUNDS(2)) dut (
    .clk_slow  (clk_slow),
    .btn_rst_n (btn_rst_n),
    .bus       (bus)
  );

  initial forever #5 clk_slow = ~clk_slow;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_slow);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [3:0] moves,
                               input logic w, input logic pt);
    bus.btn_start = start;
    bus.btn_sub   = moves[3];
    bus.btn_sub_h = moves[2];
    bus.btn_add   = moves[1];
    bus.btn_add_h = moves[0];
    bus.win       = w;
    bus.plr_turn  = pt;
  endtask

  task automatic pushExp(input string name, input logic [3:0] mv, input logic gr,
                         input logic [1:0] s0, input logic [1:0] s1, input logic over,
                         input logic winner, input logic chkTurn, input logic [3:0] turn);
    item_t it;
    it.name = name; it.mv = mv; it.gr = gr; it.s0 = s0; it.s1 = s1;
    it.over = over; it.winner = winner; it.chkTurn = chkTurn; it.turn = turn;
    sbQ.push_back(it);
  endtask

  // Queue an expectation and ask the monitor to sample the outputs at the next negedge.
  task automatic checkOutput(input string name, input logic [3:0] mv, input logic gr,
                             input logic [1:0] s0, input logic [1:0] s1, input logic over,
                             input logic winner, input logic chkTurn, input logic [3:0] turn);
    pushExp(name, mv, gr, s0, s1, over, winner, chkTurn, turn);
    probeReq = 1'b1;
    @(negedge clk_slow);
    #1;
    probeReq = 1'b0;
  endtask

  // Monitor: sole owner of the check and error counters.
  initial begin
    item_t      exp;
    logic [3:0] actMv;
    logic [10:0] act;
    logic [10:0] req;
    forever begin
      @(negedge clk_slow);
      actMv = {bus.mv_sub, bus.mv_sub_h, bus.mv_add, bus.mv_add_h};
      if (finishReq && !doneFlag) begin
        checks++;
        if (sbQ.size() != 0) begin
          errors++;
          $display("[TB] FAIL leftover: %0d expected events never seen, required 0", sbQ.size());
        end
        doneFlag = 1'b1;
      end else if (probeReq || (bus.game_rst === 1'b1) || (actMv !== 4'b0000)) begin
        checks++;
        act = {actMv, bus.game_rst, bus.score0, bus.score1, bus.match_over, bus.match_winner};
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: got mv=%b rst=%b s0=%0d s1=%0d, required no activity",
                   actMv, bus.game_rst, bus.score0, bus.score1);
        end else begin
          exp = sbQ.pop_front();
          req = {exp.mv, exp.gr, exp.s0, exp.s1, exp.over, exp.winner};
          if ((act !== req) || (exp.chkTurn && (bus.turn_left !== exp.turn))) begin
            errors++;
            $display("[TB] FAIL %s: got mv=%b rst=%b s0=%0d s1=%0d over=%b win=%b tl=%0d, required mv=%b rst=%b s0=%0d s1=%0d over=%b win=%b tl=%0d",
                     exp.name, actMv, bus.game_rst, bus.score0, bus.score1, bus.match_over,
                     bus.match_winner, bus.turn_left, exp.mv, exp.gr, exp.s0, exp.s1,
                     exp.over, exp.winner, exp.chkTurn ? exp.turn : bus.turn_left);
          end
        end
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_state", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    btn_rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_after_release", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);

    $display("[TB] start");
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    pushExp("start_game_rst", 4'b0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    checkOutput("play_turn_left", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, TL);

    $display("[TB] arbitration");
    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0);
    pushExp("arb_sub_over_add", 4'b1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (5) tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("turn_reload", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, TL);
    applyStimulus(1'b1, 4'b0101, 1'b0, 1'b1);
    pushExp("arb_subh_over_addh", 4'b0100, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1);
    pushExp("mv_add", 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    pushExp("mv_add_h", 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);

`ifdef MATCH_CTRL_TURN_TIMER_EN
    $display("[TB] timeout");
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    pushExp("timeout_p1_credit", 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (12) tick();
    tick();
    checkOutput("new_round_reload", 4'b0000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 4'd10);
    repeat (10) tick();
    checkOutput("turn_left_zero", 4'b0000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    pushExp("win_beats_timeout", 4'b0000, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("after_collision", 4'b0000, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 4'd10);
`else
    $display("[TB] timer disabled");
    repeat (50) tick();
    checkOutput("timer_disabled_no_timeout", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    pushExp("win_p1", 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("after_win_p1", 4'b0000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0);
`endif

    $display("[TB] reset mid-play");
    tick();
    btn_rst_n = 1'b0;
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    checkOutput("reset_mid_play", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    repeat (2) tick();
    btn_rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("no_start_while_held", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    pushExp("restart_game_rst", 4'b0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    checkOutput("restart_play", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, TL);
    repeat (3) tick();

    $display("[TB] match player 0");
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    pushExp("p0_round1", 4'b0000, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("match_over_p0", 4'b0000, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    pushExp("done_restart", 4'b0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    checkOutput("cleared_play", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, TL);

    $display("[TB] start ignored in play, match player 1");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("start_ignored_in_play", 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    pushExp("p1_round1", 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    checkOutput("match_over_p1", 4'b0000, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    checkOutput("done_holds_score", 4'b0000, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);

    repeat (2) tick();
    finishReq = 1'b1;
    for (int i = 0; i < 10 && !doneFlag; i++) tick();
    if (!doneFlag) begin
      $display("[TB] FAIL monitor_done: got no completion, required completion within 10 cycles");
      $fatal(1, "[TB] monitor did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
